// File: rtl/seq_det_rr_sched_pkg.sv
// Shared types and constants for the round-robin "101" sequence-detector scheduler.
package seq_det_pkg;

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    SX = 2'b11
  } ctx_t;

  localparam int NCH_DEFAULT = 4;

  // Channel-ID width, kept at least one bit so a single-channel build still has a port.
  function automatic int idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_det_rr_sched_if.sv
// Request/grant/match bundle between the serial front-ends and the detector scheduler.
interface seq_det_rr_sched_if
  import seq_det_pkg::*;
#(
  parameter int NCH   = NCH_DEFAULT,
  parameter int IDW   = idw(NCH),
  parameter int CNT_W = 8
);

  logic [NCH-1:0]   req;
  logic [NCH-1:0]   bit_in;
  logic [NCH-1:0]   ch_clr;
  logic [NCH-1:0]   gnt;
  logic             match_vld;
  logic [IDW-1:0]   match_ch;
  logic [IDW-1:0]   cnt_sel;
  logic [CNT_W-1:0] cnt_out;

  modport master (
    output req, bit_in, ch_clr, cnt_sel,
    input  gnt, match_vld, match_ch, cnt_out
  );

  modport slave (
    input  req, bit_in, ch_clr, cnt_sel,
    output gnt, match_vld, match_ch, cnt_out
  );

endinterface

// File: rtl/seq_det_rr_sched_step.sv
// One step of the overlapping "101" Mealy detector; purely combinational.
module seq101_step
  import seq_det_pkg::*;
(
  input  ctx_t state_i,
  input  logic in_i,
  output ctx_t next_state_o,
  output logic match_o
);

  // The unused 2'b11 encoding falls into the default arm and behaves exactly like S0.
  always_comb begin
    next_state_o = S0;
    match_o      = 1'b0;
    case (state_i)
      S1: next_state_o = in_i ? S1 : S2;
      S2: begin
        next_state_o = in_i ? S1 : S0;
        match_o      = in_i;
      end
      default: next_state_o = in_i ? S1 : S0;
    endcase
  end

endmodule

// File: rtl/seq_det_rr_sched.sv
// Time-multiplexes one "101" detector among NCH serial streams with round-robin grant.
// Define SEQ_DET_HIT_CNT_EN to add saturating per-channel hit counters readable via cnt_sel.
module seq_det_rr_sched
  import seq_det_pkg::*;
#(
  parameter int NCH   = NCH_DEFAULT,
  parameter int IDW   = idw(NCH),
  parameter int CNT_W = 8
)(
  input logic               clk,
  input logic               rst,
  seq_det_rr_sched_if.slave bus
);

  ctx_t           ctx_q [NCH];
  ctx_t           ctx_d [NCH];
  logic [IDW-1:0] ptr_q, ptr_d;
  logic           matchVld_q, matchVld_d;
  logic [IDW-1:0] matchCh_q, matchCh_d;

  logic [NCH-1:0] eligible;
  logic [NCH-1:0] gnt;
  logic           grantValid;
  logic [IDW-1:0] grantIdx;
  int             scanIdx;

  ctx_t           curState;
  ctx_t           nextState;
  logic           stepMatch;

  // Scan from the pointer with wrap-around; a cleared channel is never eligible, and
  // nothing is granted while reset is held.
  always_comb begin
    eligible   = bus.req & ~bus.ch_clr;
    grantValid = 1'b0;
    grantIdx   = '0;
    scanIdx    = 0;
    gnt        = '0;
    for (int off = 0; off < NCH; off++) begin
      scanIdx = (int'(ptr_q) + off) % NCH;
      if (!grantValid && eligible[scanIdx]) begin
        grantValid = 1'b1;
        grantIdx   = IDW'(scanIdx);
      end
    end
    if (rst) begin
      grantValid = 1'b0;
    end
    if (grantValid) begin
      gnt[grantIdx] = 1'b1;
    end
  end

  assign curState = ctx_q[grantIdx];

  seq101_step u_step (
    .state_i      (curState),
    .in_i         (bus.bit_in[grantIdx]),
    .next_state_o (nextState),
    .match_o      (stepMatch)
  );

  // Only the granted context advances; clears win over everything for their channel.
  always_comb begin
    ctx_d      = ctx_q;
    ptr_d      = ptr_q;
    matchVld_d = 1'b0;
    matchCh_d  = matchCh_q;
    if (grantValid) begin
      ctx_d[grantIdx] = nextState;
      ptr_d           = IDW'((int'(grantIdx) + 1) % NCH);
      matchVld_d      = stepMatch;
      matchCh_d       = grantIdx;
    end
    for (int i = 0; i < NCH; i++) begin
      if (bus.ch_clr[i]) begin
        ctx_d[i] = S0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        ctx_q[i] <= S0;
      end
      ptr_q      <= '0;
      matchVld_q <= 1'b0;
      matchCh_q  <= '0;
    end else begin
      ctx_q      <= ctx_d;
      ptr_q      <= ptr_d;
      matchVld_q <= matchVld_d;
      matchCh_q  <= matchCh_d;
    end
  end

`ifdef SEQ_DET_HIT_CNT_EN
  logic [CNT_W-1:0] hitCnt_q [NCH];
  logic [CNT_W-1:0] hitCnt_d [NCH];

  // Counters bump on the same edge that registers the match and stick at all-ones.
  always_comb begin
    hitCnt_d = hitCnt_q;
    if (grantValid && stepMatch && (hitCnt_q[grantIdx] != '1)) begin
      hitCnt_d[grantIdx] = hitCnt_q[grantIdx] + 1'b1;
    end
    for (int i = 0; i < NCH; i++) begin
      if (bus.ch_clr[i]) begin
        hitCnt_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        hitCnt_q[i] <= '0;
      end
    end else begin
      hitCnt_q <= hitCnt_d;
    end
  end
`else
  logic cntSel_unused;
  assign cntSel_unused = ^bus.cnt_sel;
`endif

  always_comb begin
    bus.gnt       = gnt;
    bus.match_vld = matchVld_q;
    bus.match_ch  = matchCh_q;
    bus.cnt_out   = '0;
`ifdef SEQ_DET_HIT_CNT_EN
    if (int'(bus.cnt_sel) < NCH) begin
      bus.cnt_out = hitCnt_q[bus.cnt_sel];
    end
`endif
  end

endmodule

// File: doc/seq_det_rr_sched.md
Name: seq_det_rr_sched

Overview:
- Time-multiplexes one "101" overlapping Mealy sequence-detector datapath among NCH serial bit streams.
- Round-robin arbitration grants one requester per cycle.
- Each channel's 2-bit detector state is saved and restored from a per-channel context register.
- Reports a registered match pulse tagged with the channel ID. Sits between serial front-ends and the event/interrupt logic.

Parameters:
- NCH, 4, number of requesting channels (2..16)
- IDW, $clog2(NCH), channel-ID width
- CNT_W, 8, per-channel hit-counter width (used only with HIT_CNT_EN)

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- req  in  NCH  per-channel request: bit_in[i] valid this cycle
- bit_in  in  NCH  per-channel serial data bit
- ch_clr  in  NCH  per-channel synchronous context clear
- gnt  out  NCH  one-hot grant, combinational, same cycle as req; the bit is consumed when gnt[i]=1
- match_vld  out  1  registered pulse: the previous cycle's granted bit completed "101"
- match_ch  out  IDW  channel ID of the match; valid only when match_vld=1
- cnt_sel  in  IDW  hit-counter read select
- cnt_out  out  CNT_W  hit count of channel cnt_sel, combinational

Behaviour:
- Reset (async, rst=1):
  - all contexts = S0; rr pointer = 0; match_vld = 0; match_ch = 0; hit counters = 0.
  - gnt = 0 while rst is high.
  - Reset mid-operation discards any in-flight match.
- Context states are S0=2'b00, S1=2'b01, S2=2'b10. 2'b11 is illegal and is treated as S0 on the next access.
- Step function (combinational), given state and input:
  - S0: in=1 -> S1; in=0 -> S0.
  - S1: in=0 -> S2; in=1 -> S1.
  - S2: in=1 -> S1 with match=1; in=0 -> S0.
  - Overlapping detection: the input 10101 gives two matches.
- Eligibility: eligible[i] = req[i] & ~ch_clr[i].
- Arbitration:
  - Scan eligible channels starting at pointer ptr, wrapping modulo NCH. The first hit gets gnt.
  - After a grant to channel k, ptr <= (k+1) mod NCH. With no grant, ptr holds.
  - At most one gnt bit is set. gnt = 0 when nothing is eligible.
- Update when gnt[k]=1:
  - ctx[k] <= step(ctx[k], bit_in[k]).
  - Next cycle: match_vld <= match and match_ch <= k.
  - Latency: bit grant to match_vld is 1 cycle.
  - With no grant, match_vld <= 0 and match_ch holds.
- Channels that are not granted keep their context unchanged. req without gnt means the requester holds its bit and retries.
- ch_clr[i]=1:
  - ctx[i] <= S0 and hit counter i <= 0.
  - It overrides a request on the same channel; that bit is dropped and not granted.
- Multiple ch_clr bits set in one cycle are all honoured. Clearing one channel does not disturb arbitration among the others.
- NCH=1 degenerates to a single detector with gnt = req & ~ch_clr.

Optional Feature:
- Macro SEQ_DET_HIT_CNT_EN.
- Defined:
  - One CNT_W-bit counter per channel, incremented when the match for that channel is registered (the same edge that sets match_vld).
  - Counters saturate at all-ones. ch_clr zeroes the counter.
  - cnt_out = count[cnt_sel]. A cnt_sel value >= NCH returns 0.
- Not defined: no counters are instantiated and cnt_out is tied to 0.

Decomposition:
- Package seq_det_pkg holds:
  - state constants S0/S1/S2 and the 2-bit state typedef;
  - the NCH default;
  - a function or constant for IDW.
- Sub-module seq101_step (pure combinational): inputs state and in; outputs next_state and match. The scheduler instantiates it once, fed from a context mux of the granted channel.
- Arbiter logic stays inline in the top module.

Test Plan:
- Single channel: req[0]=1 every cycle, bits 1,0,1,0,1 -> match_vld pulses the cycle after the 3rd and 5th grants, match_ch=0, cnt_out(sel 0)=2.
- Interleaving: all 4 channels request continuously with ptr=0:
  - gnt sequence is 0001,0010,0100,1000,0001.
  - Stream ch2 with 1,0,1 across its grants -> exactly one match with match_ch=2.
  - Other channels' contexts are unaffected.
- Context preservation: ch1 sends 1,0, then its req drops for 10 cycles while ch3 is active, then ch1 sends 1 -> a match for ch1 on the cycle after that grant.
- Clear priority: ch2 is in S2 with req=1, bit=1 and ch_clr[2]=1 in the same cycle -> gnt[2]=0, no match, ctx[2]=S0, counter 2 = 0. A following 1 moves ch2 only to S1.
- Saturation (CNT_W=2, macro defined): 5 matches on ch0 -> cnt_out=3. The same run without the macro gives cnt_out=0.
- Async reset mid-stream: assert rst between clock edges right after a matching grant -> match_vld=0 immediately, ptr=0, all contexts S0. After release, 0,1 on ch0 produces no match.
